ysyx_bus_xbar: RTL and testbench
================================

// Module: ysyx_bus_xbar
// PURPOSE
//  Parametrised N-read-client / 1-write-client AXI4 master arbiter; successor of ysyx_bus.
//  Sits between the core requestors (IFU, LSU load, future PTW/DMA read ports, LSU store)
//  and the single io_master AXI4 port of ysyx.
//  Adds round-robin arbitration with per-client bus lock, INCR bursts and per-client flush kill.
//  Keeps one outstanding transaction at a time.
// PARAMETERS
//  XLEN    32  data/address width
//  NR      3   number of read clients; client index doubles as AXI arid
//  LEN_W   8   burst length field width (AXI arlen)
//  ID_W    4   AXI id width; NR <= 2**ID_W
// PORTS
//  clock            in   1          system clock
//  reset            in   1          synchronous, active-high
//  rd_valid         in   NR         read request per client
//  rd_addr          in   NR*XLEN    read address per client (client i at [i*XLEN +: XLEN])
//  rd_len           in   NR*LEN_W   beats-1 per client
//  rd_size          in   NR*3       AXI size per client
//  rd_lock          in   NR         keep grant on this client while it keeps requesting
//  out_rd_ready     out  NR         1-cycle pulse: AR handshake done for that client
//  out_rd_valid     out  NR         1-cycle pulse per returned beat, to owning client
//  out_rd_data      out  XLEN       shared beat data
//  out_rd_last      out  1          marks final beat
//  out_rd_err       out  1          rresp != OKAY on current beat
//  wr_valid/wr_addr/wr_data  in  1/XLEN/XLEN  store request
//  wr_strb/wr_size  in   XLEN/8 / 3 byte strobes, AXI size
//  out_wr_ready     out  1          1-cycle pulse on B handshake
//  flush_pipeline   in   1          squash speculative reads
//  flush_mask       in   NR         clients affected by flush_pipeline
//  io_master_ar*    out/in  AXI4 AR: valid,addr,id,len,size,burst (INCR); ready in
//  io_master_r*     in/out  AXI4 R: valid,data,resp,last,id; rready out
//  io_master_aw*/w*/b*      AXI4 AW/W/B; awid=0, single beat, wlast=1
// BEHAVIOUR
//  - Reset: state IDLE, rr pointer 0, every out_* and io_master_*valid/ready = 0, kill = 0.
//  - FSM: IDLE -> AR -> R -> IDLE (read); IDLE -> WR -> B -> IDLE (write).
//  - IDLE arbitration, evaluated in the same cycle:
//    - wr_valid has priority over reads.
//    - Otherwise, if the last grantee has rd_lock && rd_valid, it is granted again.
//    - Otherwise, round-robin: first rd_valid at or after index rr_ptr+1 (mod NR) wins.
//    - The payload is latched into registers. arvalid rises in the next cycle (1-cycle issue latency).
//  - AR: hold arvalid with a stable payload until arready.
//    - In the handshake cycle, out_rd_ready[g] = 1, rr_ptr <= g, go to R.
//  - R: rready = 1.
//    - Each rvalid drives out_rd_valid[g] = !kill, with data/last/err.
//    - rlast returns to IDLE and clears kill.
//  - Flush: flush_pipeline && flush_mask[g] in AR or R sets kill.
//    - AR is never retracted; the burst is drained silently.
//    - A flush in the same cycle as rlast suppresses that beat.
//    - Flush in IDLE: clients in flush_mask are masked from arbitration for that cycle.
//    - Writes and non-masked clients are unaffected.
//  - WR: awvalid and wvalid are asserted together; each drops independently on its own handshake.
//    - Move to B when both are done (same or different cycles).
//  - B: bready = 1; on bvalid, out_wr_ready pulses 1 cycle, then IDLE. bresp error is ignored.
//  - A client must hold rd_valid and its payload until out_rd_ready.
//    - Deasserting rd_valid before out_rd_ready is legal only while the client is not granted.
//  - rid/bid mismatch: assertion in simulation only. No functional effect.
//  - NR = 1: rr logic degenerates; behaviour is otherwise identical.
// STRUCTURE
//  - Package ysyx_bus_pkg: bus_state_t {IDLE, AR, R, WR, B}; AXI_BURST_INCR = 2'b01;
//    AXI_RESP_OKAY = 2'b00.
//  - Sub-module ysyx_rr_arb #(NR):
//    - inputs req[NR], lock, last_gnt, ptr
//    - output one-hot gnt and encoded index
//    - purely combinational; instanced once.
//  - The top-level FSM, payload registers and kill flag live in ysyx_bus_xbar.
// TESTING
//  - Round-robin: NR=3, all rd_valid held high, no lock -> AR ids 0,1,2,0,... with equal grants.
//  - Lock: client 0 lock=1, clients 0 and 1 valid -> id 0 granted back-to-back.
//    - Lock drops -> next grant is id 1.
//  - Burst: rd_len=3, addr 0x8000_0000 -> arlen=3, burst INCR.
//    - 4 out_rd_valid[g] pulses; out_rd_last on the 4th; then IDLE.
//  - Flush mid-burst: flush on beat 2 of 4 for masked client 1 -> beats 2-4 consumed with rready=1.
//    - No out_rd_valid[1]; the next request is then granted normally.
//  - Write priority and skewed handshake:
//    - wr_valid and rd_valid raised together -> write issued first.
//    - awready at t+1, wready at t+3 -> B entered at t+3; out_wr_ready pulses once on bvalid.
//  - Reset mid-R: reset asserted during a burst -> next cycle all valids = 0 and state IDLE.
//    - Stray rvalid after reset produces no out_rd_valid.

Source files
------------

// File: rtl/ysyx_bus_pkg.sv
// Shared types and constants for the ysyx AXI4 master crossbar.
package ysyx_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    WR,
    B
  } bus_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_bus_xbar_rr_arb.sv
// Combinational round-robin picker with sticky lock on the previous grantee.
module ysyx_rr_arb
  import ysyx_bus_pkg::*;
#(
  parameter  int NR    = 3,
  localparam int IDX_W = idx_width(NR)
) (
  input  logic [NR-1:0]    req,
  input  logic             lock,
  input  logic [IDX_W-1:0] last_gnt,
  input  logic [IDX_W-1:0] ptr,
  output logic [NR-1:0]    gnt,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int unsigned cand;

  // search starts one past ptr and wraps, so ptr itself is visited last
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    if (lock && req[last_gnt]) begin
      idx   = last_gnt;
      found = 1'b1;
    end else begin
      for (int k = 1; k <= NR; k++) begin
        cand = int'(ptr) + k;
        if (cand >= NR) cand = cand - NR;
        if (!found && req[IDX_W'(cand)]) begin
          idx   = IDX_W'(cand);
          found = 1'b1;
        end
      end
    end
    gnt[idx] = found;
  end

endmodule

// File: rtl/ysyx_bus_xbar.sv
// N-read / 1-write AXI4 master arbiter: round-robin with lock, INCR bursts, flush kill.
module ysyx_bus_xbar
  import ysyx_bus_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NR    = 3,
  parameter int LEN_W = 8,
  parameter int ID_W  = 4
) (
  input  logic                clock,
  input  logic                reset,

  input  logic [NR-1:0]       rd_valid,
  input  logic [NR*XLEN-1:0]  rd_addr,
  input  logic [NR*LEN_W-1:0] rd_len,
  input  logic [NR*3-1:0]     rd_size,
  input  logic [NR-1:0]       rd_lock,
  output logic [NR-1:0]       out_rd_ready,
  output logic [NR-1:0]       out_rd_valid,
  output logic [XLEN-1:0]     out_rd_data,
  output logic                out_rd_last,
  output logic                out_rd_err,

  input  logic                wr_valid,
  input  logic [XLEN-1:0]     wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [XLEN/8-1:0]   wr_strb,
  input  logic [2:0]          wr_size,
  output logic                out_wr_ready,

  input  logic                flush_pipeline,
  input  logic [NR-1:0]       flush_mask,

  output logic                io_master_arvalid,
  input  logic                io_master_arready,
  output logic [XLEN-1:0]     io_master_araddr,
  output logic [ID_W-1:0]     io_master_arid,
  output logic [LEN_W-1:0]    io_master_arlen,
  output logic [2:0]          io_master_arsize,
  output logic [1:0]          io_master_arburst,

  input  logic                io_master_rvalid,
  output logic                io_master_rready,
  input  logic [XLEN-1:0]     io_master_rdata,
  input  logic [1:0]          io_master_rresp,
  input  logic                io_master_rlast,
  input  logic [ID_W-1:0]     io_master_rid,

  output logic                io_master_awvalid,
  input  logic                io_master_awready,
  output logic [XLEN-1:0]     io_master_awaddr,
  output logic [ID_W-1:0]     io_master_awid,
  output logic [LEN_W-1:0]    io_master_awlen,
  output logic [2:0]          io_master_awsize,
  output logic [1:0]          io_master_awburst,

  output logic                io_master_wvalid,
  input  logic                io_master_wready,
  output logic [XLEN-1:0]     io_master_wdata,
  output logic [XLEN/8-1:0]   io_master_wstrb,
  output logic                io_master_wlast,

  input  logic                io_master_bvalid,
  output logic                io_master_bready,
  input  logic [1:0]          io_master_bresp,
  input  logic [ID_W-1:0]     io_master_bid
);

  localparam int IDX_W = idx_width(NR);

  bus_state_t         state;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   rr_ptr;
  logic               any_gnt;
  logic               kill;
  logic               aw_pend;
  logic               w_pend;

  logic [XLEN-1:0]    ar_addr_q;
  logic [LEN_W-1:0]   ar_len_q;
  logic [2:0]         ar_size_q;
  logic [XLEN-1:0]    aw_addr_q;
  logic [2:0]         aw_size_q;
  logic [XLEN-1:0]    w_data_q;
  logic [XLEN/8-1:0]  w_strb_q;

  logic [NR-1:0]      arb_req;
  logic [NR-1:0]      arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   arb_ptr;
  logic               arb_lock;
  logic               arb_found;

  logic [XLEN-1:0]    sel_addr;
  logic [LEN_W-1:0]   sel_len;
  logic [2:0]         sel_size;

  logic               flush_hit;
  logic               r_beat;
  logic               ar_hs;

  // until the first grant there is no previous grantee: disable lock and start at 0
  assign arb_req  = rd_valid & ~(flush_pipeline ? flush_mask : '0);
  assign arb_ptr  = any_gnt ? rr_ptr : IDX_W'(NR - 1);
  assign arb_lock = any_gnt & rd_lock[rr_ptr];

  ysyx_rr_arb #(.NR(NR)) u_arb (
    .req      (arb_req),
    .lock     (arb_lock),
    .last_gnt (rr_ptr),
    .ptr      (arb_ptr),
    .gnt      (arb_gnt),
    .idx      (arb_idx),
    .found    (arb_found)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_size = '0;
    for (int i = 0; i < NR; i++) begin
      if (arb_gnt[i]) begin
        sel_addr = rd_addr[i*XLEN +: XLEN];
        sel_len  = rd_len[i*LEN_W +: LEN_W];
        sel_size = rd_size[i*3 +: 3];
      end
    end
  end

  assign flush_hit = flush_pipeline && flush_mask[gnt_idx];
  assign r_beat    = (state == R) && io_master_rvalid;
  assign ar_hs     = (state == AR) && io_master_arready;

  always_comb begin
    out_rd_ready = '0;
    out_rd_valid = '0;
    for (int i = 0; i < NR; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        out_rd_ready[i] = ar_hs;
        out_rd_valid[i] = r_beat && !kill && !flush_hit;
      end
    end
  end

  assign out_rd_data  = r_beat ? io_master_rdata : '0;
  assign out_rd_last  = r_beat && io_master_rlast;
  assign out_rd_err   = r_beat && (io_master_rresp != AXI_RESP_OKAY);
  assign out_wr_ready = (state == B) && io_master_bvalid;

  assign io_master_arvalid = (state == AR);
  assign io_master_araddr  = ar_addr_q;
  assign io_master_arid    = ID_W'(gnt_idx);
  assign io_master_arlen   = ar_len_q;
  assign io_master_arsize  = ar_size_q;
  assign io_master_arburst = AXI_BURST_INCR;
  assign io_master_rready  = (state == R);

  assign io_master_awvalid = (state == WR) && aw_pend;
  assign io_master_awaddr  = aw_addr_q;
  assign io_master_awid    = '0;
  assign io_master_awlen   = '0;
  assign io_master_awsize  = aw_size_q;
  assign io_master_awburst = AXI_BURST_INCR;
  assign io_master_wvalid  = (state == WR) && w_pend;
  assign io_master_wdata   = w_data_q;
  assign io_master_wstrb   = w_strb_q;
  assign io_master_wlast   = 1'b1;
  assign io_master_bready  = (state == B);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      gnt_idx   <= '0;
      rr_ptr    <= '0;
      any_gnt   <= 1'b0;
      kill      <= 1'b0;
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_size_q <= '0;
      aw_addr_q <= '0;
      aw_size_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_valid) begin
            aw_addr_q <= wr_addr;
            aw_size_q <= wr_size;
            w_data_q  <= wr_data;
            w_strb_q  <= wr_strb;
            aw_pend   <= 1'b1;
            w_pend    <= 1'b1;
            state     <= WR;
          end else if (arb_found) begin
            ar_addr_q <= sel_addr;
            ar_len_q  <= sel_len;
            ar_size_q <= sel_size;
            gnt_idx   <= arb_idx;
            state     <= AR;
          end
        end
        AR: begin
          if (flush_hit) kill <= 1'b1;
          if (io_master_arready) begin
            rr_ptr  <= gnt_idx;
            any_gnt <= 1'b1;
            state   <= R;
          end
        end
        R: begin
          // a killed burst is still drained to rlast so the slave stays in sync
          if (io_master_rvalid && io_master_rlast) begin
            kill  <= 1'b0;
            state <= IDLE;
          end else if (flush_hit) begin
            kill <= 1'b1;
          end
        end
        WR: begin
          if (io_master_awready) aw_pend <= 1'b0;
          if (io_master_wready)  w_pend  <= 1'b0;
          if ((!aw_pend || io_master_awready) && (!w_pend || io_master_wready))
            state <= B;
        end
        B: begin
          if (io_master_bvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  rid_match: assert property (@(posedge clock) disable iff (reset)
    r_beat |-> (io_master_rid == ID_W'(gnt_idx)));

  bid_match: assert property (@(posedge clock) disable iff (reset)
    ((state == B) && io_master_bvalid) |-> ((io_master_bid == '0) && !$isunknown(io_master_bresp)));

endmodule

// File: tb/tb_ysyx_bus_xbar.sv
// Directed bench for ysyx_bus_xbar: arbitration, lock, bursts, flush, write skew, reset.
module tb_ysyx_bus_xbar;
  import ysyx_bus_pkg::*;

  localparam int XLEN  = 32;
  localparam int NR    = 3;
  localparam int LEN_W = 8;
  localparam int ID_W  = 4;

  logic                clock;
  logic                reset;
  logic [NR-1:0]       rd_valid;
  logic [NR*XLEN-1:0]  rd_addr;
  logic [NR*LEN_W-1:0] rd_len;
  logic [NR*3-1:0]     rd_size;
  logic [NR-1:0]       rd_lock;
  logic [NR-1:0]       out_rd_ready;
  logic [NR-1:0]       out_rd_valid;
  logic [XLEN-1:0]     out_rd_data;
  logic                out_rd_last;
  logic                out_rd_err;
  logic                wr_valid;
  logic [XLEN-1:0]     wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic [XLEN/8-1:0]   wr_strb;
  logic [2:0]          wr_size;
  logic                out_wr_ready;
  logic                flush_pipeline;
  logic [NR-1:0]       flush_mask;
  logic                io_master_arvalid;
  logic                io_master_arready;
  logic [XLEN-1:0]     io_master_araddr;
  logic [ID_W-1:0]     io_master_arid;
  logic [LEN_W-1:0]    io_master_arlen;
  logic [2:0]          io_master_arsize;
  logic [1:0]          io_master_arburst;
  logic                io_master_rvalid;
  logic                io_master_rready;
  logic [XLEN-1:0]     io_master_rdata;
  logic [1:0]          io_master_rresp;
  logic                io_master_rlast;
  logic [ID_W-1:0]     io_master_rid;
  logic                io_master_awvalid;
  logic                io_master_awready;
  logic [XLEN-1:0]     io_master_awaddr;
  logic [ID_W-1:0]     io_master_awid;
  logic [LEN_W-1:0]    io_master_awlen;
  logic [2:0]          io_master_awsize;
  logic [1:0]          io_master_awburst;
  logic                io_master_wvalid;
  logic                io_master_wready;
  logic [XLEN-1:0]     io_master_wdata;
  logic [XLEN/8-1:0]   io_master_wstrb;
  logic                io_master_wlast;
  logic                io_master_bvalid;
  logic                io_master_bready;
  logic [1:0]          io_master_bresp;
  logic [ID_W-1:0]     io_master_bid;

  int checks = 0;
  int errors = 0;
  int grant_cnt [NR];

  ysyx_bus_xbar #(.XLEN(XLEN), .NR(NR), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_len(rd_len), .rd_size(rd_size),
    .rd_lock(rd_lock), .out_rd_ready(out_rd_ready), .out_rd_valid(out_rd_valid),
    .out_rd_data(out_rd_data), .out_rd_last(out_rd_last), .out_rd_err(out_rd_err),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_size(wr_size), .out_wr_ready(out_wr_ready),
    .flush_pipeline(flush_pipeline), .flush_mask(flush_mask),
    .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
    .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
    .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst),
    .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
    .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp),
    .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid),
    .io_master_awvalid(io_master_awvalid), .io_master_awready(io_master_awready),
    .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid),
    .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
    .io_master_awburst(io_master_awburst),
    .io_master_wvalid(io_master_wvalid), .io_master_wready(io_master_wready),
    .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
    .io_master_wlast(io_master_wlast),
    .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready),
    .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_client(input int i, input logic [31:0] a, input logic [7:0] l);
    rd_addr[i*XLEN +: XLEN]   = a;
    rd_len[i*LEN_W +: LEN_W]  = l;
    rd_size[i*3 +: 3]         = 3'd2;
  endtask

  // full read: AR handshake then len+1 beats; beats at/after flush_beat must be swallowed
  task automatic rd_txn(input int id, input logic [31:0] addr, input int len, input int flush_beat);
    int n;
    n = 0;
    while (!io_master_arvalid && n < 20) begin
      tick();
      n++;
    end
    chk("arvalid", io_master_arvalid, 1);
    chk("arid", io_master_arid, id);
    chk("araddr", io_master_araddr, addr);
    chk("arlen", io_master_arlen, len);
    chk("arsize", io_master_arsize, 2);
    chk("arburst", io_master_arburst, 1);
    chk("rd_ready_pre", out_rd_ready, 0);
    if (io_master_arid < NR) grant_cnt[io_master_arid]++;
    io_master_arready = 1'b1;
    #1;
    chk("rd_ready", out_rd_ready, 1 << id);
    tick();
    io_master_arready = 1'b0;
    for (int b = 0; b <= len; b++) begin
      io_master_rvalid = 1'b1;
      io_master_rid    = ID_W'(id);
      io_master_rdata  = 32'hD000_0000 + (id << 8) + b;
      io_master_rresp  = (b == 1) ? 2'b10 : 2'b00;
      io_master_rlast  = (b == len);
      flush_pipeline   = (b == flush_beat);
      flush_mask       = (b == flush_beat) ? NR'(1 << id) : '0;
      #1;
      chk("rready", io_master_rready, 1);
      if (flush_beat >= 0 && b >= flush_beat) begin
        chk("rd_valid_killed", out_rd_valid, 0);
      end else begin
        chk("rd_valid", out_rd_valid, 1 << id);
        chk("rd_data", out_rd_data, 32'hD000_0000 + (id << 8) + b);
        chk("rd_last", out_rd_last, (b == len));
        chk("rd_err", out_rd_err, (b == 1));
      end
      tick();
    end
    io_master_rvalid = 1'b0;
    io_master_rlast  = 1'b0;
    flush_pipeline   = 1'b0;
    flush_mask       = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < NR; i++) grant_cnt[i] = 0;
    reset = 1'b1;
    rd_valid = '0; rd_addr = '0; rd_len = '0; rd_size = '0; rd_lock = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0; wr_size = '0;
    flush_pipeline = 1'b0; flush_mask = '0;
    io_master_arready = 1'b0; io_master_rvalid = 1'b0; io_master_rdata = '0;
    io_master_rresp = '0; io_master_rlast = 1'b0; io_master_rid = '0;
    io_master_awready = 1'b0; io_master_wready = 1'b0;
    io_master_bvalid = 1'b0; io_master_bresp = '0; io_master_bid = '0;
    tick();
    tick();

    chk("rst_arvalid", io_master_arvalid, 0);
    chk("rst_rready", io_master_rready, 0);
    chk("rst_awvalid", io_master_awvalid, 0);
    chk("rst_wvalid", io_master_wvalid, 0);
    chk("rst_bready", io_master_bready, 0);
    chk("rst_rd_ready", out_rd_ready, 0);
    chk("rst_rd_valid", out_rd_valid, 0);
    chk("rst_wr_ready", out_wr_ready, 0);
    chk("rst_state", dut.state, IDLE);
    reset = 1'b0;

    // round robin, all clients requesting
    for (int i = 0; i < NR; i++) set_client(i, 32'h1000_0000 + i * 32'h100, 8'd0);
    rd_valid = 3'b111;
    for (int t = 0; t < 6; t++) rd_txn(t % 3, 32'h1000_0000 + (t % 3) * 32'h100, 0, -1);
    for (int i = 0; i < NR; i++) chk("rr_equal", grant_cnt[i], 2);

    // lock on client 0
    rd_valid = 3'b011;
    rd_lock  = 3'b001;
    rd_txn(0, 32'h1000_0000, 0, -1);
    rd_txn(0, 32'h1000_0000, 0, -1);
    rd_lock = 3'b000;
    rd_txn(1, 32'h1000_0100, 0, -1);

    // 4-beat INCR burst
    rd_valid = 3'b100;
    set_client(2, 32'h8000_0000, 8'd3);
    rd_txn(2, 32'h8000_0000, 3, -1);
    rd_valid = 3'b000;
    chk("burst_idle_rready", io_master_rready, 0);
    tick();
    chk("burst_idle_state", dut.state, IDLE);

    // flush on beat 2 of 4 for client 1, then a clean request
    set_client(1, 32'h2000_0040, 8'd3);
    rd_valid = 3'b010;
    rd_txn(1, 32'h2000_0040, 3, 1);
    rd_txn(1, 32'h2000_0040, 3, -1);
    rd_valid = 3'b000;

    // write priority with skewed AW/W handshakes
    set_client(0, 32'h1000_0000, 8'd0);
    rd_valid = 3'b001;
    wr_valid = 1'b1; wr_addr = 32'h3000_0010; wr_data = 32'hCAFE_BABE;
    wr_strb = 4'b1100; wr_size = 3'd2;
    tick();
    chk("wr_first_ar", io_master_arvalid, 0);
    chk("wr_awvalid", io_master_awvalid, 1);
    chk("wr_wvalid", io_master_wvalid, 1);
    chk("wr_awaddr", io_master_awaddr, 32'h3000_0010);
    chk("wr_wdata", io_master_wdata, 32'hCAFE_BABE);
    chk("wr_wstrb", io_master_wstrb, 4'b1100);
    chk("wr_awid", io_master_awid, 0);
    chk("wr_wlast", io_master_wlast, 1);
    tick();
    io_master_awready = 1'b1;
    tick();
    io_master_awready = 1'b0;
    chk("wr_aw_dropped", io_master_awvalid, 0);
    chk("wr_w_held", io_master_wvalid, 1);
    chk("wr_no_b_yet", io_master_bready, 0);
    tick();
    io_master_wready = 1'b1;
    #1;
    chk("wr_pre_b", io_master_bready, 0);
    tick();
    io_master_wready = 1'b0;
    chk("wr_w_dropped", io_master_wvalid, 0);
    chk("wr_in_b", io_master_bready, 1);
    tick();
    chk("wr_ready_wait", out_wr_ready, 0);
    io_master_bvalid = 1'b1;
    io_master_bresp  = 2'b10;
    #1;
    chk("wr_ready_pulse", out_wr_ready, 1);
    tick();
    io_master_bvalid = 1'b0;
    io_master_bresp  = 2'b00;
    wr_valid = 1'b0;
    chk("wr_ready_once", out_wr_ready, 0);
    chk("wr_b_done", io_master_bready, 0);
    rd_txn(0, 32'h1000_0000, 0, -1);
    rd_valid = 3'b000;

    // reset asserted in the middle of a burst
    rd_valid = 3'b010;
    n = 0;
    while (!io_master_arvalid && n < 20) begin
      tick();
      n++;
    end
    chk("mid_arid", io_master_arid, 1);
    io_master_arready = 1'b1;
    tick();
    io_master_arready = 1'b0;
    rd_valid = 3'b000;
    io_master_rvalid = 1'b1; io_master_rid = 4'd1; io_master_rlast = 1'b0;
    io_master_rdata = 32'h1234_5678; io_master_rresp = 2'b00;
    #1;
    chk("mid_beat", out_rd_valid, 3'b010);
    tick();
    io_master_rvalid = 1'b0;
    reset = 1'b1;
    tick();
    chk("mid_rst_arvalid", io_master_arvalid, 0);
    chk("mid_rst_rready", io_master_rready, 0);
    chk("mid_rst_awvalid", io_master_awvalid, 0);
    chk("mid_rst_wvalid", io_master_wvalid, 0);
    chk("mid_rst_state", dut.state, IDLE);
    reset = 1'b0;
    io_master_rvalid = 1'b1; io_master_rid = 4'd1; io_master_rlast = 1'b1;
    #1;
    chk("stray_rvalid", out_rd_valid, 0);
    tick();
    io_master_rvalid = 1'b0;
    io_master_rlast  = 1'b0;

    // flush in IDLE masks client 0 from arbitration for that cycle
    set_client(1, 32'h2000_0040, 8'd0);
    rd_valid = 3'b011;
    flush_pipeline = 1'b1;
    flush_mask = 3'b001;
    tick();
    flush_pipeline = 1'b0;
    flush_mask = '0;
    rd_txn(1, 32'h2000_0040, 0, -1);
    rd_valid = 3'b000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
